// File: rtl/meter_cmd_scheduler.sv
// Parking-meter command sequencer: merges button requests and the 1 Hz tick into one
// LOAD/ADD/DEC stream on a valid/ready port, and drives the expired-state blink enable.
module meter_cmd_scheduler #(
  parameter int unsigned CLK_HZ    = 100,
  parameter int unsigned BLINK_DIV = 50,
  parameter int unsigned RST1_VAL  = 16,
  parameter int unsigned RST2_VAL  = 150,
  parameter int unsigned ADD1_VAL  = 60,
  parameter int unsigned ADD2_VAL  = 120,
  parameter int unsigned ADD3_VAL  = 180,
  parameter int unsigned ADD4_VAL  = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rst1_req,
  input  logic        rst2_req,
  input  logic [3:0]  add_req,
  input  logic        meter_zero,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [1:0]  cmd_op,
  output logic [13:0] cmd_data,
  output logic        blink,
  output logic        req_drop,
  output logic        dec_overrun
);

  localparam int unsigned DivW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned BlkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [1:0] OpAdd  = 2'd0;
  localparam logic [1:0] OpLoad = 2'd1;
  localparam logic [1:0] OpDec  = 2'd2;

  typedef enum logic [0:0] {StIdle, StOffer} state_e;

  // Button vector: [5]=rst1, [4]=rst2, [3:0]=add4..add1; bit index order equals priority.
  logic [5:0] raw;
  logic [5:0] sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d, edge_q, edge_d;
  logic [5:0] pend_q, pend_d;
  logic       dec_pend_q, dec_pend_d;
  logic [DivW-1:0] div_q, div_d;
  logic [BlkW-1:0] blk_cnt_q, blk_cnt_d;
  logic       blink_q, blink_d, zprev_q, zprev_d;
  logic       drop_q, drop_d, ovr_q, ovr_d;
  state_e     state_q, state_d;
  logic [6:0] sel_q, sel_d;
  logic       valid_q, valid_d;
  logic [1:0] op_q, op_d;
  logic [13:0] data_q, data_d;

  logic       xfer, tick, dec_set;
  logic [6:0] clr, all_pend, win;
  logic [1:0] win_op;
  logic [13:0] win_data;

  assign raw = {rst1_req, rst2_req, add_req};

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    edge_d  = sync2_q & ~sync3_q;

    xfer    = valid_q & cmd_ready;
    clr     = xfer ? sel_q : 7'd0;
    tick    = (div_q == DivW'(CLK_HZ - 1));
    div_d   = tick ? '0 : div_q + 1'b1;
    dec_set = tick & ~meter_zero;

    // A new edge and a transfer of the same bit together leave the bit set, no drop.
    pend_d     = (pend_q & ~clr[5:0]) | edge_q;
    drop_d     = |(edge_q & pend_q & ~clr[5:0]);
    dec_pend_d = (dec_pend_q & ~clr[6]) | dec_set;
    ovr_d      = dec_set & dec_pend_q & ~clr[6];

    // The bit being transferred is excluded so back-to-back picks a different winner.
    all_pend = {dec_pend_q, pend_q} & ~clr;
    win = '0;
    for (int i = 0; i < 7; i++) begin
      if (all_pend[i]) begin
        win    = '0;
        win[i] = 1'b1;
      end
    end

    unique case (win)
      7'b100_0000: begin win_op = OpDec;  win_data = 14'd0;           end
      7'b010_0000: begin win_op = OpLoad; win_data = 14'(RST1_VAL);   end
      7'b001_0000: begin win_op = OpLoad; win_data = 14'(RST2_VAL);   end
      7'b000_1000: begin win_op = OpAdd;  win_data = 14'(ADD4_VAL);   end
      7'b000_0100: begin win_op = OpAdd;  win_data = 14'(ADD3_VAL);   end
      7'b000_0010: begin win_op = OpAdd;  win_data = 14'(ADD2_VAL);   end
      7'b000_0001: begin win_op = OpAdd;  win_data = 14'(ADD1_VAL);   end
      default:     begin win_op = OpAdd;  win_data = 14'd0;           end
    endcase

    state_d = state_q;
    valid_d = valid_q;
    sel_d   = sel_q;
    op_d    = op_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (|all_pend) begin
          state_d = StOffer;
          valid_d = 1'b1;
          sel_d   = win;
          op_d    = win_op;
          data_d  = win_data;
        end
      end
      StOffer: begin
        if (xfer) begin
          if (|all_pend) begin
            sel_d  = win;
            op_d   = win_op;
            data_d = win_data;
          end else begin
            state_d = StIdle;
            valid_d = 1'b0;
            sel_d   = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    zprev_d = meter_zero;
    if (!meter_zero) begin
      blink_d   = 1'b1;
      blk_cnt_d = '0;
    end else if (!zprev_q) begin
      blink_d   = 1'b0;
      blk_cnt_d = '0;
    end else if (blk_cnt_q == BlkW'(BLINK_DIV - 1)) begin
      blink_d   = ~blink_q;
      blk_cnt_d = '0;
    end else begin
      blink_d   = blink_q;
      blk_cnt_d = blk_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      sync3_q    <= '0;
      edge_q     <= '0;
      pend_q     <= '0;
      dec_pend_q <= 1'b0;
      div_q      <= '0;
      blk_cnt_q  <= '0;
      blink_q    <= 1'b1;
      zprev_q    <= 1'b0;
      drop_q     <= 1'b0;
      ovr_q      <= 1'b0;
      state_q    <= StIdle;
      sel_q      <= '0;
      valid_q    <= 1'b0;
      op_q       <= OpAdd;
      data_q     <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sync3_q    <= sync3_d;
      edge_q     <= edge_d;
      pend_q     <= pend_d;
      dec_pend_q <= dec_pend_d;
      div_q      <= div_d;
      blk_cnt_q  <= blk_cnt_d;
      blink_q    <= blink_d;
      zprev_q    <= zprev_d;
      drop_q     <= drop_d;
      ovr_q      <= ovr_d;
      state_q    <= state_d;
      sel_q      <= sel_d;
      valid_q    <= valid_d;
      op_q       <= op_d;
      data_q     <= data_d;
    end
  end

  assign cmd_valid   = valid_q;
  assign cmd_op      = op_q;
  assign cmd_data    = data_q;
  assign blink       = blink_q;
  assign req_drop    = drop_q;
  assign dec_overrun = ovr_q;

endmodule

// File: tb/tb_meter_cmd_scheduler.sv
// Scoreboard bench for meter_cmd_scheduler: stimulus pushes expected commands, a negedge
// monitor pops them on every transfer and checks op/data stability while stalled.
module tb_meter_cmd_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rst1_req = 1'b0;
  logic        rst2_req = 1'b0;
  logic [3:0]  add_req = 4'd0;
  logic        meter_zero = 1'b0;
  logic        cmd_ready = 1'b0;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [13:0] cmd_data;
  logic        blink;
  logic        req_drop;
  logic        dec_overrun;

  meter_cmd_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .rst1_req    (rst1_req),
    .rst2_req    (rst2_req),
    .add_req     (add_req),
    .meter_zero  (meter_zero),
    .cmd_ready   (cmd_ready),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .cmd_data    (cmd_data),
    .blink       (blink),
    .req_drop    (req_drop),
    .dec_overrun (dec_overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  op;
    logic [13:0] data;
  } cmd_t;

  cmd_t exp_q[$];
  cmd_t held;
  cmd_t exp_c;
  logic held_vld = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   xfer_cnt = 0;
  int   drop_cnt = 0;
  int   ovr_cnt = 0;

  function automatic cmd_t mk(input int op, input int data);
    cmd_t c;
    c.op   = 2'(op);
    c.data = 14'(data);
    return c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic wait_valid(input int max, input string nm);
    int n = 0;
    while (cmd_valid !== 1'b1 && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, 32'(cmd_valid), 32'd1);
  endtask

  // Monitor: every transfer pops one expected command; stalled offers must hold steady.
  always @(negedge clk) begin
    if (req_drop === 1'b1) drop_cnt++;
    if (dec_overrun === 1'b1) ovr_cnt++;
    if (cmd_valid !== 1'b1) begin
      held_vld = 1'b0;
    end else begin
      if (held_vld) chk("hold_stable", 32'({cmd_op, cmd_data}), 32'(held));
      if (cmd_ready === 1'b1) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_cmd: got op=%0d data=%0d expected none", cmd_op, cmd_data);
        end else begin
          exp_c = exp_q.pop_front();
          chk("cmd_op_data", 32'({cmd_op, cmd_data}), 32'(exp_c));
        end
        held_vld = 1'b0;
      end else begin
        held_vld = 1'b1;
        held     = {cmd_op, cmd_data};
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    // Reset values while held in reset
    #12;
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_op", 32'(cmd_op), 32'd0);
    chk("rst_data", 32'(cmd_data), 32'd0);
    chk("rst_blink", 32'(blink), 32'd1);
    chk("rst_drop", 32'(req_drop), 32'd0);
    chk("rst_ovr", 32'(dec_overrun), 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Blink: on while time remains, then 50 off / 50 on after meter_zero rises
    repeat (3) @(posedge clk);
    #1 chk("blink_live", 32'(blink), 32'd1);
    meter_zero = 1'b1;
    @(posedge clk); #1 chk("blink_first_off", 32'(blink), 32'd0);
    repeat (49) @(posedge clk);
    #1 chk("blink_off_end", 32'(blink), 32'd0);
    @(posedge clk); #1 chk("blink_on_start", 32'(blink), 32'd1);
    repeat (49) @(posedge clk);
    #1 chk("blink_on_end", 32'(blink), 32'd1);
    @(posedge clk); #1 chk("blink_off_again", 32'(blink), 32'd0);

    // Mid-offer reset: command lost, nothing after release
    cmd_ready  = 1'b0;
    add_req[0] = 1'b1;
    wait_valid(10, "t1_offer");
    chk("t1_offer_data", 32'({cmd_op, cmd_data}), 32'(mk(0, 60)));
    add_req = 4'd0;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("t1_valid_drop", 32'(cmd_valid), 32'd0);
    chk("t1_op", 32'(cmd_op), 32'd0);
    chk("t1_data", 32'(cmd_data), 32'd0);
    chk("t1_blink", 32'(blink), 32'd1);
    #20 rst = 1'b1;
    cmd_ready = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1 if (cmd_valid) seen = 1'b1;
    end
    chk("t1_no_cmd", 32'(seen), 32'd0);

    // add4 latency: valid exactly at edge 4, one cycle wide
    add_req = 4'b1000;
    exp_q.push_back(mk(0, 300));
    repeat (3) @(posedge clk);
    #1 add_req = 4'd0;
    @(posedge clk); #1 chk("t2_edge3", 32'(cmd_valid), 32'd0);
    @(posedge clk); #1 chk("t2_edge4", 32'(cmd_valid), 32'd1);
    @(posedge clk); #1 chk("t2_edge5", 32'(cmd_valid), 32'd0);

    // rst1 + add3 + add1 together under a stall
    cmd_ready  = 1'b0;
    rst1_req   = 1'b1;
    add_req    = 4'b0101;
    exp_q.push_back(mk(1, 16));
    exp_q.push_back(mk(0, 180));
    exp_q.push_back(mk(0, 60));
    repeat (3) @(posedge clk);
    #1;
    rst1_req = 1'b0;
    add_req  = 4'd0;
    wait_valid(10, "t3_offer");
    chk("t3_first_load", 32'({cmd_op, cmd_data}), 32'(mk(1, 16)));
    repeat (5) @(posedge clk);
    #1 cmd_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("t3_drained", 32'(exp_q.size()), 32'd0);
    chk("t3_idle", 32'(cmd_valid), 32'd0);

    // Second add2 edge while pending is dropped
    cmd_ready = 1'b0;
    drop_cnt  = 0;
    add_req   = 4'b0010;
    exp_q.push_back(mk(0, 120));
    repeat (3) @(posedge clk);
    #1 add_req = 4'd0;
    repeat (3) @(posedge clk);
    #1 add_req = 4'b0010;
    repeat (3) @(posedge clk);
    #1 add_req = 4'd0;
    repeat (6) @(posedge clk);
    #1;
    chk("t6_drop_pulses", 32'(drop_cnt), 32'd1);
    chk("t6_offer", 32'({cmd_valid, cmd_op, cmd_data}), 32'({1'b1, mk(0, 120)}));
    cmd_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_drained", 32'(exp_q.size()), 32'd0);
    chk("t6_idle", 32'(cmd_valid), 32'd0);

    // Ticks: add2 pending on a tick cycle -> DEC then ADD 120; DEC period 100
    exp_q.push_back(mk(2, 0));
    meter_zero = 1'b0;
    wait_valid(150, "t4_first_dec");
    chk("t4_first_dec_op", 32'(cmd_op), 32'd2);
    repeat (95) @(posedge clk);
    #1 add_req = 4'b0010;
    exp_q.push_back(mk(2, 0));
    exp_q.push_back(mk(0, 120));
    exp_q.push_back(mk(2, 0));
    repeat (3) @(posedge clk);
    #1 add_req = 4'd0;
    repeat (2) @(posedge clk);
    #1 chk("t4_dec_wins", 32'({cmd_valid, cmd_op, cmd_data}), 32'({1'b1, mk(2, 0)}));
    @(posedge clk);
    #1 chk("t4_add_next", 32'({cmd_valid, cmd_op, cmd_data}), 32'({1'b1, mk(0, 120)}));
    repeat (99) @(posedge clk);
    #1 chk("t4_dec_period", 32'({cmd_valid, cmd_op, cmd_data}), 32'({1'b1, mk(2, 0)}));

    // Long stall: overrun pulses, only one DEC survives
    @(posedge clk);
    #1;
    cmd_ready = 1'b0;
    ovr_cnt   = 0;
    repeat (250) @(posedge clk);
    #1;
    chk("t5_overrun", 32'(ovr_cnt), 32'd1);
    exp_q.push_back(mk(2, 0));
    meter_zero = 1'b1;
    cmd_ready  = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("t5_drained", 32'(exp_q.size()), 32'd0);
    chk("xfer_total", 32'(xfer_cnt), 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
